// File: rtl/pc_ras_if.sv
// pc_ras_if: decode/control to pc_ras_unit bus
// master drives the control and operand fields and receives the PC and RAS view.
// slave is the unit itself.
interface pc_ras_if #(
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 26,
    parameter int OFF_WIDTH = 16,
    parameter int RAS_DEPTH = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    logic                 en;
    logic [2:0]           pc_src;
    logic [IMM_WIDTH-1:0] imm;
    logic [OFF_WIDTH-1:0] offset;
    logic [PC_WIDTH-1:0]  jr_target;
    logic                 flag_clear;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  ras_top;
    logic [CW-1:0]        ras_count;
    logic                 ras_overflow;
    logic                 ras_underflow;
    modport master (
        output en, pc_src, imm, offset, jr_target, flag_clear,
        input  pc, ras_top, ras_count, ras_overflow, ras_underflow
    );
    modport slave (
        input  en, pc_src, imm, offset, jr_target, flag_clear,
        output pc, ras_top, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: next-PC select (SEQ/JMP/BR/RET/CALL/JR) with an internal circular return-address stack
// Ports: clock, reset (async, active-high), bus (pc_ras_if.slave).
module pc_ras_unit #(
    parameter int                     PC_WIDTH  = 32,
    parameter int                     IMM_WIDTH = 26,
    parameter int                     OFF_WIDTH = 16,
    parameter int                     RAS_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0
) (
    input logic       clock,
    input logic       reset,
    pc_ras_if.slave   bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, RET = 3'd3, CALL = 3'd4, JR = 3'd5;
    logic [PC_WIDTH-1:0] stack [RAS_DEPTH];
    logic [PC_WIDTH-1:0] pc, next_pc, seq_pc, jmp_pc, br_pc, top;
    logic [PW-1:0]       tp;
    logic [CW-1:0]       count;
    logic                ovf, unf, empty, full, is_call, is_ret, push, pop;
    always_comb begin
        empty   = count == '0;
        full    = count == CW'(RAS_DEPTH);
        is_call = bus.pc_src == CALL;
        is_ret  = bus.pc_src == RET;
        push    = bus.en && is_call;
        pop     = bus.en && is_ret && !empty;
        top     = empty ? '0 : stack[tp];
        seq_pc  = pc + PC_WIDTH'(1);
        jmp_pc  = {pc[PC_WIDTH-1:IMM_WIDTH], bus.imm};
        br_pc   = pc + PC_WIDTH'($signed(bus.offset));
        next_pc = bus.pc_src == SEQ  ? seq_pc :
                  bus.pc_src == JMP  ? jmp_pc :
                  bus.pc_src == BR   ? br_pc :
                  bus.pc_src == RET  ? (empty ? seq_pc : top) :
                  bus.pc_src == CALL ? jmp_pc :
                  bus.pc_src == JR   ? bus.jr_target : pc;
    end
    // tp addresses the current top; a push when full lands on the oldest slot, which is exactly tp+1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            tp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (bus.en) pc <= next_pc;
            tp    <= push ? tp + PW'(1) : pop ? tp - PW'(1) : tp;
            count <= (push && !full) ? count + CW'(1) : pop ? count - CW'(1) : count;
            ovf   <= (push && full) || (ovf && !bus.flag_clear);
            unf   <= (bus.en && is_ret && empty) || (unf && !bus.flag_clear);
        end
    end
    always_ff @(posedge clock)
        if (push) stack[tp + PW'(1)] <= seq_pc;
    assign bus.pc            = pc;
    assign bus.ras_top       = top;
    assign bus.ras_count     = count;
    assign bus.ras_overflow  = ovf;
    assign bus.ras_underflow = unf;
endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: vector table, corner sequences and randomized run against a queue-based model
module tb_pc_ras_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    pc_ras_if bus ();
    pc_ras_unit dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [2:0]  src;
        logic [25:0] imm;
        logic [15:0] off;
        logic [31:0] jr;
        logic        fc;
        logic [31:0] e_pc;
        logic [3:0]  e_cnt;
        logic [31:0] e_top;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] src, input logic [25:0] imm,
                         input logic [15:0] off, input logic [31:0] jr, input logic fc);
        bus.en = en; bus.pc_src = src; bus.imm = imm; bus.offset = off; bus.jr_target = jr; bus.flag_clear = fc;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string n, input logic [31:0] p, input logic [3:0] c,
                           input logic [31:0] t, input logic o, input logic u);
        chk({n, "_pc"}, bus.pc, p);
        chk({n, "_cnt"}, 32'(bus.ras_count), 32'(c));
        chk({n, "_top"}, bus.ras_top, t);
        chk({n, "_ovf"}, 32'(bus.ras_overflow), 32'(o));
        chk({n, "_unf"}, 32'(bus.ras_underflow), 32'(u));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 3'd0, '0, '0, '0, 1'b0);
        step();
        step();
        reset = 1'b0;
    endtask

    vec_t vt [18];
    logic [31:0] mpc, np, ptmp;
    logic [31:0] q [$];
    logic mo, mu, so, su;
    logic ren, rfc;
    logic [2:0] rsrc;
    logic [25:0] rimm;
    logic [15:0] roff;
    logic [31:0] rjr;

    initial begin
        vt[0]  = '{1, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 0, 0, 32'h2, 0, 0, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 0, 0, 32'h3, 0, 0, 0, 0};
        vt[3]  = '{1, 5, 0, 0, 32'h0400_0010, 0, 32'h0400_0010, 0, 0, 0, 0};
        vt[4]  = '{1, 1, 26'h2, 0, 0, 0, 32'h0400_0002, 0, 0, 0, 0};
        vt[5]  = '{1, 2, 0, 16'hFFFE, 0, 0, 32'h0400_0000, 0, 0, 0, 0};
        vt[6]  = '{1, 2, 0, 16'd10, 0, 0, 32'h0400_000A, 0, 0, 0, 0};
        vt[7]  = '{1, 5, 0, 0, 32'h5, 0, 32'h5, 0, 0, 0, 0};
        vt[8]  = '{1, 4, 26'h40, 0, 0, 0, 32'h40, 1, 32'h6, 0, 0};
        vt[9]  = '{1, 0, 0, 0, 0, 0, 32'h41, 1, 32'h6, 0, 0};
        vt[10] = '{1, 3, 0, 0, 0, 0, 32'h6, 0, 0, 0, 0};
        vt[11] = '{1, 3, 0, 0, 0, 0, 32'h7, 0, 0, 0, 1};
        vt[12] = '{1, 6, 0, 0, 0, 0, 32'h7, 0, 0, 0, 1};
        vt[13] = '{0, 0, 0, 0, 0, 0, 32'h7, 0, 0, 0, 1};
        vt[14] = '{1, 0, 0, 0, 0, 1, 32'h8, 0, 0, 0, 0};
        vt[15] = '{1, 5, 0, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 0, 0, 0, 0};
        vt[16] = '{1, 2, 0, 16'd3, 0, 0, 32'h1, 0, 0, 0, 0};
        vt[17] = '{1, 3, 0, 0, 0, 1, 32'h2, 0, 0, 0, 1};

        drive(1'b1, 3'd0, '0, '0, '0, 1'b0);
        step();
        chk_all("reset", 32'h0, 0, 0, 0, 0);
        reset = 1'b0;
        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].src, vt[i].imm, vt[i].off, vt[i].jr, vt[i].fc);
            step();
            chk_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_cnt, vt[i].e_top, vt[i].e_ovf, vt[i].e_unf);
        end

        // nine nested calls overflow an 8-deep stack; returns come back newest first
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                drive(1'b1, 3'd5, '0, '0, 32'(i), 1'b0);
                step();
            end
            drive(1'b1, 3'd4, 26'(i + 'h100), '0, '0, 1'b0);
            step();
        end
        chk_all("ovf", 32'h108, 8, 32'h9, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd3, '0, '0, '0, 1'b0);
            step();
            chk($sformatf("ret%0d_pc", i), bus.pc, 32'(9 - i));
        end
        chk("ret_cnt", 32'(bus.ras_count), 0);
        drive(1'b1, 3'd3, '0, '0, '0, 1'b0);
        step();
        chk_all("ret_unf", 32'h3, 0, 0, 1, 1);

        // stall with CALL pending, flags cleared mid-stall
        drive(1'b1, 3'd4, 26'h50, '0, '0, 1'b0);
        step();
        chk_all("pre_stall", 32'h50, 1, 32'h4, 1, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd4, 26'h77, '0, '0, i == 2);
            step();
            chk_all($sformatf("stall%0d", i), 32'h50, 1, 32'h4, i < 2, i < 2);
        end

        // asynchronous reset in the middle of a CALL cycle
        drive(1'b1, 3'd4, 26'h99, '0, '0, 1'b0);
        #3 reset = 1'b1;
        #1 chk_all("async_rst", 32'h0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        chk_all("rst_hold", 32'h0, 0, 0, 0, 0);
        drive(1'b1, 3'd0, '0, '0, '0, 1'b0);
        step();
        chk_all("post_rst", 32'h1, 0, 0, 0, 0);

        // randomized run against a list-of-return-addresses model
        do_reset();
        mpc = 0; q = {}; mo = 0; mu = 0;
        for (int n = 0; n < 400; n++) begin
            ren  = ($urandom % 8) != 0;
            rsrc = 3'($urandom % 8);
            rfc  = ($urandom % 10) == 0;
            rimm = 26'($urandom);
            roff = 16'($urandom);
            rjr  = $urandom;
            so = 0; su = 0; np = mpc;
            if (ren) begin
                case (rsrc)
                    3'd0: np = mpc + 1;
                    3'd1: np = {mpc[31:26], rimm};
                    3'd2: np = mpc + {{16{roff[15]}}, roff};
                    3'd3: if (q.size() > 0) np = q.pop_back(); else begin np = mpc + 1; su = 1; end
                    3'd4: begin
                        np = {mpc[31:26], rimm};
                        ptmp = mpc + 1;
                        q.push_back(ptmp);
                        if (q.size() > 8) begin void'(q.pop_front()); so = 1; end
                    end
                    3'd5: np = rjr;
                    default: np = mpc;
                endcase
            end
            mpc = np;
            mo = so | (mo & ~rfc);
            mu = su | (mu & ~rfc);
            drive(ren, rsrc, rimm, roff, rjr, rfc);
            step();
            chk_all($sformatf("rnd%0d", n), mpc, 4'(q.size()), q.size() > 0 ? q[$] : 32'h0, mo, mu);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program-counter unit for the instruction-memory front end.
- Selects the next PC from five sources:
  - sequential
  - absolute immediate jump
  - PC-relative signed branch
  - register jump
  - call/return
- Owns an internal circular return-address stack (RAS), replacing the externally supplied stack top.
- Sits between decode/control (which drives `pc_src` and the operands) and instruction memory (which consumes `pc`).

Parameters:
- PC_WIDTH, 32: width of `pc`, `jr_target`, RAS entries.
- IMM_WIDTH, 26: width of the absolute jump immediate; must be less than PC_WIDTH.
- OFF_WIDTH, 16: width of the signed branch offset; must be at most PC_WIDTH.
- RAS_DEPTH, 8: number of RAS entries; power of two, at least 2.
- RESET_PC, 0: value loaded into `pc` on reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance enable; low means all state holds (stall)
- pc_src  in  3  next-PC select: 0 SEQ, 1 JMP, 2 BR, 3 RET, 4 CALL, 5 JR, 6–7 reserved
- imm  in  IMM_WIDTH  absolute jump target field (JMP, CALL)
- offset  in  OFF_WIDTH  signed branch offset (BR)
- jr_target  in  PC_WIDTH  register jump target (JR)
- flag_clear  in  1  clears the sticky overflow/underflow flags
- pc  out  PC_WIDTH  current program counter (registered)
- ras_top  out  PC_WIDTH  current RAS top entry; 0 when empty
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries
- ras_overflow  out  1  sticky: a CALL was made while the RAS was full
- ras_underflow  out  1  sticky: a RET was made while the RAS was empty

Behaviour:
- Reset (asynchronous, active-high, independent of `en`):
  - `pc` = RESET_PC
  - `ras_count` = 0, `ras_top` = 0
  - both flags = 0
  - top pointer = 0; RAS contents are don't-care
  - Reset mid-sequence discards all pending stack state.
- Next-PC is combinational from the current `pc` and inputs. All registers update on the rising edge when `en` = 1. `pc` shows the new value one cycle after `pc_src` is applied (latency 1).
- All arithmetic is modulo 2^PC_WIDTH; carries out are discarded. Wrap-around is legal, not an error.
- Source rules:
  - SEQ: `pc` + 1.
  - JMP: {`pc`[PC_WIDTH-1:IMM_WIDTH], `imm`}. Upper bits are taken from the current `pc`, not `pc` + 1.
  - BR: `pc` + sign_extend(`offset`) to PC_WIDTH.
  - JR: `jr_target`.
  - CALL:
    - Jump as for JMP.
    - Push `pc` + 1 onto the RAS.
    - If `ras_count` < RAS_DEPTH, increment `ras_count`.
    - If full: overwrite the oldest entry (circular), keep `ras_count` = RAS_DEPTH, set `ras_overflow`. Stack then holds the most recent RAS_DEPTH return addresses.
  - RET:
    - If `ras_count` > 0: `pc` = `ras_top`; decrement `ras_count`; `ras_top` shows the next entry on the following cycle.
    - If `ras_count` = 0: `pc` = `pc` + 1; set `ras_underflow`; count stays 0.
  - Reserved (6, 7): `pc` holds; RAS unchanged.
- `en` = 0: `pc`, RAS, count and flags all hold, whatever `pc_src` is.
- `flag_clear`:
  - Synchronous, acts regardless of `en`.
  - If a set condition occurs in the same cycle, the set wins.
- `ras_top` is a registered-state view (entry at the top pointer when count > 0), not the in-flight push.
- Pointer arithmetic wraps modulo RAS_DEPTH. No entry is ever returned after it has been overwritten.

Test Plan:
- Reset then SEQ for 3 cycles (RESET_PC = 0) -> `pc` = 0, 1, 2, 3; `ras_count` = 0; flags 0.
- From `pc` = 0x0400_0010: JMP with `imm` = 2 -> `pc` = 0x0400_0002. Then BR with `offset` = 16'hFFFE -> `pc` = 0x0400_0000. Then BR with `offset` = 10 -> `pc` = 0x0400_000A.
- At `pc` = 5: CALL with `imm` = 0x40 -> `pc` = 0x40, `ras_top` = 6, count 1. SEQ to 0x41, then RET -> `pc` = 6, count 0. Second RET -> `pc` = 7, `ras_underflow` = 1.
- RAS_DEPTH = 8: 9 nested CALLs from `pc`s 0..8 (each `imm` = `pc` + 0x100) -> count 8, `ras_overflow` = 1. 8 RETs return 9, 8, …, 2 in order. A 9th RET underflows.
- `en` = 0 for 4 cycles with `pc_src` = CALL -> `pc`, count and `ras_top` unchanged. `flag_clear` pulsed during the stall -> both flags clear.
- BR at `pc` = 0xFFFF_FFFE with `offset` = 3 -> `pc` = 1 (wrap). Assert `reset` asynchronously mid-cycle during a CALL -> `pc` = RESET_PC immediately, count 0, no push recorded.
